color_poly_xform: RTL and testbench
===================================

Name: color_poly_xform

Overview:
- Parametrised successor to the fixed-parameter pixel colour transform; sits between the pixel source and the write FIFO.
- Applies a third-order polynomial colour-correction matrix to each pixel: 3 output channels, 18 monomial terms each.
- Coefficients are signed, runtime-loadable and double-buffered, and swap at frame start.
- Adds round-and-shift fixed point, ambient offset, output clamping, FIFO backpressure, bypass mode and a clip counter.

Parameters:
- PIX_W, 8: bits per colour channel.
- COORD_W, 10: x/y coordinate width.
- COEF_W, 20: signed coefficient width, two's complement, format Q(COEF_W-FRAC_BITS).FRAC_BITS.
- FRAC_BITS, 16: fractional bits; the result is rounded, then arithmetic-shifted right by FRAC_BITS.
- AMB_SHIFT, 0: signed ambient offset, added after the shift.
- CLIP_W, 16: clip counter width.

Ports:
- clk_25, in, 1: pixel clock.
- reset, in, 1: asynchronous, active-low reset.
- valid, in, 1: input pixel valid.
- in_ready, out, 1: pixel is accepted when valid && in_ready.
- x_i, in, COORD_W: pixel x coordinate.
- y_i, in, COORD_W: pixel y coordinate.
- red_i, in, PIX_W: input red.
- green_i, in, PIX_W: input green.
- blue_i, in, PIX_W: input blue.
- cfg_we, in, 1: write strobe, shadow coefficient bank.
- cfg_addr, in, 6: coefficient address = channel*18 + term.
- cfg_data, in, COEF_W: coefficient value.
- cfg_commit, in, 1: request shadow-to-active swap.
- cfg_bypass, in, 1: when 1, pass pixels through unchanged.
- wrfull, in, 1: downstream FIFO full.
- wrreq, out, 1: FIFO write strobe.
- wrclk_25, out, 1: equal to clk_25.
- x_o, out, COORD_W: output x coordinate.
- y_o, out, COORD_W: output y coordinate.
- red_o, out, PIX_W: output red.
- green_o, out, PIX_W: output green.
- blue_o, out, PIX_W: output blue.
- commit_pending, out, 1: a commit request is waiting for frame start.
- clip_cnt, out, CLIP_W: count of pixels with any channel clamped.

Behaviour:
- Term order, index 0..17: R3, G3, B3, R2G, RG2, G2B, GB2, B2R, BR2, R2, G2, B2, RG, GB, BR, R, G, B.
- Channel order: 0 = red, 1 = green, 2 = blue.
- Reset (async, reset==0):
  - Outputs: wrreq=0, x_o=0, y_o=0, red_o=0, green_o=0, blue_o=0, commit_pending=0, clip_cnt=0.
  - All stage valids = 0.
  - Both coefficient banks load identity: coef[c][15+c] = 1<<FRAC_BITS, all others 0.
- Pipeline: 4 register stages.
  - S1 registers the 18 unsigned monomials (up to 3*PIX_W bits), coordinates and bypass flag.
  - S2 registers the 54 signed products, each COEF_W+3*PIX_W+1 bits.
  - S3 registers 3 sums, ACC_W = COEF_W+3*PIX_W+6 bits.
  - S4 computes (sum + 2^(FRAC_BITS-1)) >>> FRAC_BITS, adds AMB_SHIFT, clamps to [0, 2^PIX_W-1], and registers the outputs.
- Latency: 4 cycles from acceptance to wrreq when there is no stall.
- Backpressure:
  - advance = !(v4 && wrfull); in_ready = advance.
  - wrreq = v4 && !wrfull.
  - On !advance, every stage holds, outputs are stable, and nothing is lost or duplicated.
  - Fully pipelined: 1 pixel/cycle when wrfull is 0.
- Bypass: the flag is captured per pixel at S1. A bypassed pixel emerges with the same 4-cycle latency, RGB unchanged, and never counts as clipped.
- Coefficient writes:
  - cfg_we writes the shadow bank only.
  - cfg_addr >= 54 is ignored.
  - Writes are allowed at any time and never affect pixels in flight.
- Commit:
  - cfg_commit sets commit_pending.
  - The active bank takes the shadow bank on the first accepted pixel with x_i==0 && y_i==0 while pending; that pixel and all later pixels use the new set.
  - Pending clears and clip_cnt clears on the same cycle.
  - Commit while already pending has no extra effect.
  - cfg_we in the swap cycle: the write lands in shadow only; active takes the pre-write shadow.
- Clip counter:
  - Increments when a pixel leaves S4 (wrreq=1) with any channel clamped.
  - Saturates at all-ones.
  - A clear on the same cycle as an increment gives 0 (the clear wins).
- Reset mid-operation: in-flight pixels are discarded, wrreq drops immediately, and there is no partial output.

Decomposition:
- Package color_poly_pkg holds:
  - NUM_TERMS=18, NUM_CH=3.
  - Term index localparams T_R3..T_B.
  - ACC_W derivation function.
  - Identity-coefficient function.
- One sub-module, color_poly_coef_bank:
  - Contains the shadow and active banks, commit_pending and the swap logic.
  - Exposes the flattened active coefficients to the datapath.

Test Plan:
- Reset, then (x=5, y=7, R=10, G=20, B=30) → 4 cycles later: wrreq=1, (5, 7, 10, 20, 30); in_ready=1 throughout.
- Shadow write coef[0][15]=0x08000 (0.5) plus commit, then pixels at (3,0) and (0,0) with R=200:
  - (3,0) gives red_o=200, since old coefficients still apply.
  - (0,0) gives red_o=100; commit_pending goes 1 then 0.
- Clamp with coef[1][16]=0x20000 (2.0) and coef[2][17]=-0x10000, input (100, 200, 50):
  - Output is green_o=255 and blue_o=0.
  - clip_cnt goes 0→1.
- Backpressure: stream 8 pixels, hold wrfull=1 for 5 cycles mid-stream → outputs hold, in_ready=0, and exactly 8 in-order writes occur.
- Bypass=1 with the non-identity set from the clamp scenario, input (100, 200, 50) → (100, 200, 50) after 4 cycles; clip_cnt unchanged.
- Assert reset with 3 pixels in flight → wrreq=0 at once; no stale output after release; coefficients return to identity.

Source files
------------

// File: rtl/color_poly_pkg.sv
// Shared constants and helpers for the polynomial colour-correction datapath.
package color_poly_pkg;

  localparam int unsigned NUM_TERMS = 18;
  localparam int unsigned NUM_CH    = 3;
  localparam int unsigned NUM_COEF  = NUM_TERMS * NUM_CH;

  localparam int unsigned T_R3  = 0;
  localparam int unsigned T_G3  = 1;
  localparam int unsigned T_B3  = 2;
  localparam int unsigned T_R2G = 3;
  localparam int unsigned T_RG2 = 4;
  localparam int unsigned T_G2B = 5;
  localparam int unsigned T_GB2 = 6;
  localparam int unsigned T_B2R = 7;
  localparam int unsigned T_BR2 = 8;
  localparam int unsigned T_R2  = 9;
  localparam int unsigned T_G2  = 10;
  localparam int unsigned T_B2  = 11;
  localparam int unsigned T_RG  = 12;
  localparam int unsigned T_GB  = 13;
  localparam int unsigned T_BR  = 14;
  localparam int unsigned T_R   = 15;
  localparam int unsigned T_G   = 16;
  localparam int unsigned T_B   = 17;

  function automatic int unsigned acc_width(input int unsigned coef_w, input int unsigned pix_w);
    return coef_w + 3 * pix_w + 6;
  endfunction

  // Identity matrix: each channel passes its own linear term at unity gain.
  function automatic logic signed [31:0] ident_coef(input int unsigned addr, input int unsigned frac_bits);
    if ((addr % NUM_TERMS) == (T_R + addr / NUM_TERMS))
      return 32'sd1 <<< frac_bits;
    else
      return '0;
  endfunction

endpackage

// File: rtl/color_poly_coef_bank.sv
// Double-buffered coefficient storage: shadow takes writes, active swaps in at frame start.
module color_poly_coef_bank
  import color_poly_pkg::*;
#(
  parameter int unsigned COEF_W    = 20,
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic                               clk_25,
  input  logic                               reset,
  input  logic                               cfg_we,
  input  logic [5:0]                         cfg_addr,
  input  logic [COEF_W-1:0]                  cfg_data,
  input  logic                               cfg_commit,
  input  logic                               frame_start,
  output logic                               commit_pending,
  output logic                               swap,
  output logic [NUM_COEF-1:0][COEF_W-1:0]    active
);

  logic [NUM_COEF-1:0][COEF_W-1:0] shadow;

  assign swap = frame_start && commit_pending;

  // Active copies the pre-write shadow because both updates are non-blocking.
  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_COEF; i++) begin
        shadow[i] <= COEF_W'(ident_coef(i, FRAC_BITS));
        active[i] <= COEF_W'(ident_coef(i, FRAC_BITS));
      end
      commit_pending <= 1'b0;
    end else begin
      if (cfg_we && (32'(cfg_addr) < NUM_COEF))
        shadow[cfg_addr] <= cfg_data;
      if (swap)
        active <= shadow;
      if (swap)
        commit_pending <= 1'b0;
      else if (cfg_commit)
        commit_pending <= 1'b1;
    end
  end

endmodule

// File: rtl/color_poly_xform.sv
// Four-stage third-order colour-correction pipeline with clamping, bypass and FIFO backpressure.
module color_poly_xform
  import color_poly_pkg::*;
#(
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned COORD_W   = 10,
  parameter int unsigned COEF_W    = 20,
  parameter int unsigned FRAC_BITS = 16,
  parameter int          AMB_SHIFT = 0,
  parameter int unsigned CLIP_W    = 16
) (
  input  logic               clk_25,
  input  logic               reset,
  input  logic               valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] x_i,
  input  logic [COORD_W-1:0] y_i,
  input  logic [PIX_W-1:0]   red_i,
  input  logic [PIX_W-1:0]   green_i,
  input  logic [PIX_W-1:0]   blue_i,
  input  logic               cfg_we,
  input  logic [5:0]         cfg_addr,
  input  logic [COEF_W-1:0]  cfg_data,
  input  logic               cfg_commit,
  input  logic               cfg_bypass,
  input  logic               wrfull,
  output logic               wrreq,
  output logic               wrclk_25,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic [PIX_W-1:0]   red_o,
  output logic [PIX_W-1:0]   green_o,
  output logic [PIX_W-1:0]   blue_o,
  output logic               commit_pending,
  output logic [CLIP_W-1:0]  clip_cnt
);

  localparam int unsigned MW    = 3 * PIX_W;
  localparam int unsigned PW    = COEF_W + MW + 1;
  localparam int unsigned ACC_W = acc_width(COEF_W, PIX_W);

  localparam logic signed [ACC_W-1:0] ROUND   = ACC_W'(1) << (FRAC_BITS - 1);
  localparam logic signed [ACC_W-1:0] AMB     = ACC_W'(AMB_SHIFT);
  localparam logic signed [ACC_W-1:0] PIX_MAX = ACC_W'((1 << PIX_W) - 1);

  logic advance, accept, swap;
  logic [NUM_COEF-1:0][COEF_W-1:0] active;

  logic v1, v2, v3, v4;
  logic [COORD_W-1:0] x1, y1, x2, y2, x3, y3;
  logic [NUM_CH-1:0][PIX_W-1:0] rgb1, rgb2, rgb3;
  logic byp1, byp2, byp3, clip4;

  logic [NUM_TERMS-1:0][MW-1:0]           mono_d, mono1;
  logic [NUM_CH-1:0][NUM_TERMS-1:0][PW-1:0] prod_d, prod2;
  logic [NUM_CH-1:0][ACC_W-1:0]           acc_d, acc3;
  logic [NUM_CH-1:0][PIX_W-1:0]           pix_d;
  logic                                   clip_d;

  assign advance  = !(v4 && wrfull);
  assign in_ready = advance;
  assign accept   = valid && advance;
  assign wrreq    = v4 && !wrfull;
  assign wrclk_25 = clk_25;

  color_poly_coef_bank #(
    .COEF_W    (COEF_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_coef_bank (
    .clk_25         (clk_25),
    .reset          (reset),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .cfg_commit     (cfg_commit),
    .frame_start    (accept && (x_i == '0) && (y_i == '0)),
    .commit_pending (commit_pending),
    .swap           (swap),
    .active         (active)
  );

  always_comb begin
    logic [MW-1:0] r, g, b;
    r = MW'(red_i);
    g = MW'(green_i);
    b = MW'(blue_i);
    mono_d        = '0;
    mono_d[T_R3]  = r * r * r;
    mono_d[T_G3]  = g * g * g;
    mono_d[T_B3]  = b * b * b;
    mono_d[T_R2G] = r * r * g;
    mono_d[T_RG2] = r * g * g;
    mono_d[T_G2B] = g * g * b;
    mono_d[T_GB2] = g * b * b;
    mono_d[T_B2R] = b * b * r;
    mono_d[T_BR2] = b * r * r;
    mono_d[T_R2]  = r * r;
    mono_d[T_G2]  = g * g;
    mono_d[T_B2]  = b * b;
    mono_d[T_RG]  = r * g;
    mono_d[T_GB]  = g * b;
    mono_d[T_BR]  = b * r;
    mono_d[T_R]   = r;
    mono_d[T_G]   = g;
    mono_d[T_B]   = b;
  end

  // Products sample the active bank while the pixel sits in S1, so a swap
  // lands exactly on the frame-start pixel and never on older ones.
  always_comb begin
    logic signed [PW-1:0] a, m;
    prod_d = '0;
    a      = '0;
    m      = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      for (int unsigned t = 0; t < NUM_TERMS; t++) begin
        a = {{(PW-COEF_W){active[c*NUM_TERMS+t][COEF_W-1]}}, active[c*NUM_TERMS+t]};
        m = PW'({1'b0, mono1[t]});
        prod_d[c][t] = a * m;
      end
    end
  end

  always_comb begin
    acc_d = '0;
    for (int unsigned c = 0; c < NUM_CH; c++)
      for (int unsigned t = 0; t < NUM_TERMS; t++)
        acc_d[c] = acc_d[c] + {{(ACC_W-PW){prod2[c][t][PW-1]}}, prod2[c][t]};
  end

  always_comb begin
    logic signed [ACC_W-1:0] val;
    val    = '0;
    pix_d  = '0;
    clip_d = 1'b0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      val = (($signed(acc3[c]) + ROUND) >>> FRAC_BITS) + AMB;
      if (byp3) begin
        pix_d[c] = rgb3[c];
      end else if (val < 0) begin
        pix_d[c] = '0;
        clip_d   = 1'b1;
      end else if (val > PIX_MAX) begin
        pix_d[c] = '1;
        clip_d   = 1'b1;
      end else begin
        pix_d[c] = val[PIX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0;
      x1 <= '0; y1 <= '0; x2 <= '0; y2 <= '0; x3 <= '0; y3 <= '0;
      rgb1 <= '0; rgb2 <= '0; rgb3 <= '0;
      byp1 <= 1'b0; byp2 <= 1'b0; byp3 <= 1'b0; clip4 <= 1'b0;
      mono1 <= '0; prod2 <= '0; acc3 <= '0;
      x_o <= '0; y_o <= '0; red_o <= '0; green_o <= '0; blue_o <= '0;
    end else if (advance) begin
      v1 <= accept;
      if (accept) begin
        mono1 <= mono_d;
        x1    <= x_i;
        y1    <= y_i;
        rgb1  <= {blue_i, green_i, red_i};
        byp1  <= cfg_bypass;
      end
      v2 <= v1;
      if (v1) begin
        prod2 <= prod_d;
        x2 <= x1; y2 <= y1; rgb2 <= rgb1; byp2 <= byp1;
      end
      v3 <= v2;
      if (v2) begin
        acc3 <= acc_d;
        x3 <= x2; y3 <= y2; rgb3 <= rgb2; byp3 <= byp2;
      end
      v4 <= v3;
      if (v3) begin
        x_o     <= x3;
        y_o     <= y3;
        red_o   <= pix_d[0];
        green_o <= pix_d[1];
        blue_o  <= pix_d[2];
        clip4   <= clip_d;
      end
    end
  end

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset)
      clip_cnt <= '0;
    else if (swap)
      clip_cnt <= '0;
    else if (wrreq && clip4 && (clip_cnt != '1))
      clip_cnt <= clip_cnt + 1'b1;
  end

endmodule

// File: tb/tb_color_poly_xform.sv
// Scoreboard bench: driver predicts each accepted pixel from a matrix model; monitor checks writes.
module tb_color_poly_xform;

  localparam int PIX_W   = 8;
  localparam int COORD_W = 10;
  localparam int COEF_W  = 20;
  localparam int CLIP_W  = 16;

  logic clk_25 = 1'b0;
  logic reset = 1'b0;
  logic valid = 1'b0;
  logic in_ready;
  logic [COORD_W-1:0] x_i = '0, y_i = '0;
  logic [PIX_W-1:0] red_i = '0, green_i = '0, blue_i = '0;
  logic cfg_we = 1'b0, cfg_commit = 1'b0, cfg_bypass = 1'b0, wrfull = 1'b0;
  logic [5:0] cfg_addr = '0;
  logic [COEF_W-1:0] cfg_data = '0;
  logic wrreq, wrclk_25, commit_pending;
  logic [COORD_W-1:0] x_o, y_o;
  logic [PIX_W-1:0] red_o, green_o, blue_o;
  logic [CLIP_W-1:0] clip_cnt;

  always #5 clk_25 = ~clk_25;

  color_poly_xform #(
    .PIX_W(PIX_W), .COORD_W(COORD_W), .COEF_W(COEF_W),
    .FRAC_BITS(16), .AMB_SHIFT(0), .CLIP_W(CLIP_W)
  ) dut (
    .clk_25(clk_25), .reset(reset), .valid(valid), .in_ready(in_ready),
    .x_i(x_i), .y_i(y_i), .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_commit(cfg_commit), .cfg_bypass(cfg_bypass), .wrfull(wrfull),
    .wrreq(wrreq), .wrclk_25(wrclk_25), .x_o(x_o), .y_o(y_o),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .commit_pending(commit_pending), .clip_cnt(clip_cnt)
  );

  typedef struct {
    int x; int y; int rgb[3]; bit clip;
  } exp_t;

  exp_t   q[$];
  int     checks = 0;
  int     errors = 0;
  int     writes = 0;
  longint m_shadow[54];
  longint m_active[54];
  bit     m_pending;
  bit     swap_now = 1'b0;
  int     exp_clip = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 54; i++) begin
      m_shadow[i] = ((i % 18) == 15 + i / 18) ? 65536 : 0;
      m_active[i] = m_shadow[i];
    end
    m_pending = 1'b0;
  endfunction

  // out[c] = clamp(round(sum_t coef[c][t] * monomial_t / 2^16))
  function automatic exp_t predict(input int x, input int y, input int r, input int g,
                                   input int b, input bit byp);
    exp_t   e;
    longint R = r, G = g, B = b;
    longint mono[18];
    longint s, v;
    mono = '{R*R*R, G*G*G, B*B*B, R*R*G, R*G*G, G*G*B, G*B*B, B*B*R, B*R*R,
             R*R, G*G, B*B, R*G, G*B, B*R, R, G, B};
    e.x = x; e.y = y; e.clip = 1'b0;
    e.rgb[0] = r; e.rgb[1] = g; e.rgb[2] = b;
    if (!byp) begin
      for (int c = 0; c < 3; c++) begin
        s = 0;
        for (int t = 0; t < 18; t++) s += m_active[c*18+t] * mono[t];
        v = (s + 32768) >>> 16;
        if (v < 0) begin v = 0; e.clip = 1'b1; end
        else if (v > 255) begin v = 255; e.clip = 1'b1; end
        e.rgb[c] = int'(v);
      end
    end
    return e;
  endfunction

  task automatic step(input bit v, input int x, input int y, input int r, input int g,
                      input int b, input bit byp, input bit we, input int addr,
                      input longint data, input bit commit, input bit full, output bit acc);
    bit sw;
    @(posedge clk_25);
    #1;
    valid = v; x_i = COORD_W'(x); y_i = COORD_W'(y);
    red_i = PIX_W'(r); green_i = PIX_W'(g); blue_i = PIX_W'(b);
    cfg_bypass = byp; cfg_we = we; cfg_addr = 6'(addr); cfg_data = COEF_W'(data);
    cfg_commit = commit; wrfull = full;
    #1;
    check("commit_pending", commit_pending, m_pending);
    acc = v && in_ready;
    sw = acc && x == 0 && y == 0 && m_pending;
    swap_now = sw;
    if (sw) m_active = m_shadow;
    if (acc) q.push_back(predict(x, y, r, g, b, byp));
    if (we && addr < 54) m_shadow[addr] = data;
    if (sw) m_pending = 1'b0;
    else if (commit) m_pending = 1'b1;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, acc);
  endtask

  task automatic pix(input int x, input int y, input int r, input int g, input int b,
                     input bit byp);
    bit acc = 1'b0;
    int n = 0;
    while (!acc && n < 20) begin
      step(1, x, y, r, g, b, byp, 0, 0, 0, 0, 0, acc);
      n++;
    end
    if (!acc) check("accept_timeout", 0, 1);
  endtask

  task automatic cfg_write(input int addr, input longint data);
    bit acc;
    step(0, 0, 0, 0, 0, 0, 0, 1, addr, data, 0, 0, acc);
  endtask

  task automatic commit();
    bit acc;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, acc);
  endtask

  task automatic do_reset();
    @(posedge clk_25);
    #1;
    reset = 1'b0;
    valid = 1'b0; wrfull = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0; cfg_bypass = 1'b0;
    swap_now = 1'b0;
    q.delete();
    model_reset();
    #1;
    check("wrreq_in_reset", wrreq, 0);
    check("red_o_in_reset", red_o, 0);
    check("x_o_in_reset", x_o, 0);
    check("clip_in_reset", clip_cnt, 0);
    check("pending_in_reset", commit_pending, 0);
    repeat (2) @(posedge clk_25);
    #1;
    reset = 1'b1;
  endtask

  // Monitor: clip_cnt reflects the previous edge; a write seen now lands on the next edge.
  initial begin
    exp_t e;
    bit   got_clip;
    forever begin
      @(negedge clk_25);
      if (!reset) begin
        exp_clip = 0;
      end else begin
        check("clip_cnt", clip_cnt, exp_clip);
        got_clip = 1'b0;
        if (wrreq) begin
          writes++;
          if (q.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            e = q.pop_front();
            check("x_o", x_o, e.x);
            check("y_o", y_o, e.y);
            check("red_o", red_o, e.rgb[0]);
            check("green_o", green_o, e.rgb[1]);
            check("blue_o", blue_o, e.rgb[2]);
            got_clip = e.clip;
          end
        end
        if (swap_now) exp_clip = 0;
        else if (wrreq && got_clip && exp_clip != 65535) exp_clip++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int w0, nacc;
    model_reset();
    do_reset();

    // Identity pass-through and 4-cycle latency.
    pix(5, 7, 10, 20, 30, 0);
    check("in_ready_idle", in_ready, 1);
    for (int k = 1; k <= 4; k++) begin
      idle(1);
      check("latency_wrreq", wrreq, k == 4);
    end
    idle(4);

    // Coefficient swap only at frame start.
    cfg_write(15, 'h08000);
    commit();
    pix(3, 0, 200, 0, 0, 0);
    pix(0, 0, 200, 0, 0, 0);
    idle(8);

    // Clamping high and low.
    cfg_write(18 + 16, 'h20000);
    cfg_write(36 + 17, -'h10000);
    commit();
    pix(0, 0, 100, 200, 50, 0);
    idle(8);

    // Bypass ignores the non-identity set and is never clipped.
    pix(1, 1, 100, 200, 50, 1);
    idle(8);

    // Backpressure: 5 stalled cycles mid-stream, 8 in-order writes.
    w0 = writes;
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      pix(10 + i, 3, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 0);
      nacc++;
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 16, 3, 1, 2, 3, 0, 0, 0, 0, 0, 1, acc);
      check("in_ready_stall", in_ready, 0);
    end
    for (int i = 6; i < 8; i++) begin
      pix(10 + i, 3, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 0);
      nacc++;
    end
    idle(10);
    check("stream_writes", writes - w0, nacc);

    // Randomized traffic with config churn and backpressure.
    for (int i = 0; i < 1500; i++) begin
      int     addr, t;
      longint d;
      addr = $urandom_range(0, 63);
      t = addr % 18;
      if (t < 9) d = longint'($urandom_range(0, 2)) - 1;
      else if (t < 15) d = longint'($urandom_range(0, 128)) - 64;
      else d = longint'($urandom_range(0, 'h30000)) - 'h18000;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
           $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
           $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, addr, d,
           $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, acc);
    end
    idle(10);

    // Reset with pixels in flight restores identity coefficients.
    cfg_write(15, 'h08000);
    commit();
    pix(0, 0, 200, 100, 50, 0);
    pix(1, 0, 40, 50, 60, 0);
    pix(2, 0, 70, 80, 90, 0);
    do_reset();
    idle(8);
    pix(2, 2, 10, 20, 30, 0);
    idle(8);

    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
